adam_apb_arbiter: RTL

ADAM_APB_ARBITER -- requirements
Module: adam_apb_arbiter

---
 rtl/adam_apb_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/adam_apb_arbiter.sv
// adam_apb_arbiter: shares one APB master port among NO_MSTS requesters.
// Grants are round-robin, and a transfer is never split or aborted once it
// has been granted. A pause handshake lets a controller park the bus
// between transfers.
// Optional ACCESS-phase watchdog: define ADAM_APB_ARB_TIMEOUT_EN to enable it.
module adam_apb_arbiter #(
    parameter int NO_MSTS        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    seq_clk,
    input  logic                    seq_rst,
    input  logic                    pause_req,
    output logic                    pause_ack,

    input  logic [NO_MSTS-1:0]      s_psel,
    input  logic [NO_MSTS-1:0]      s_penable,
    input  logic [NO_MSTS-1:0]      s_pwrite,
    input  logic [ADDR_WIDTH-1:0]   s_paddr  [NO_MSTS],
    input  logic [DATA_WIDTH-1:0]   s_pwdata [NO_MSTS],
    input  logic [DATA_WIDTH/8-1:0] s_pstrb  [NO_MSTS],
    input  logic [2:0]              s_pprot  [NO_MSTS],
    output logic [NO_MSTS-1:0]      s_pready,
    output logic [NO_MSTS-1:0]      s_pslverr,
    output logic [DATA_WIDTH-1:0]   s_prdata [NO_MSTS],

    output logic                    m_psel,
    output logic                    m_penable,
    output logic                    m_pwrite,
    output logic [ADDR_WIDTH-1:0]   m_paddr,
    output logic [DATA_WIDTH-1:0]   m_pwdata,
    output logic [DATA_WIDTH/8-1:0] m_pstrb,
    output logic [2:0]              m_pprot,
    input  logic                    m_pready,
    input  logic [DATA_WIDTH-1:0]   m_prdata,
    input  logic                    m_pslverr
);

    localparam int GW     = (NO_MSTS > 1) ? $clog2(NO_MSTS) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, PAUSED} state_t;

    state_t                  state_reg, state_next;
    logic [GW-1:0]           grant_reg;
    logic [GW-1:0]           last_grant_reg;
    logic                    pwrite_reg;
    logic [ADDR_WIDTH-1:0]   paddr_reg;
    logic [DATA_WIDTH-1:0]   pwdata_reg;
    logic [STRB_W-1:0]       pstrb_reg;
    logic [2:0]              pprot_reg;

    logic                    arb_found;
    logic [GW-1:0]           arb_idx;
    logic [GW-1:0]           cand;
    logic                    timeout_hit;
    logic                    xfer_done;
    logic                    resp_valid;

    // Only s_psel marks a request; the requester's own penable carries no meaning here.
    logic                    unused_penable;
    assign unused_penable = ^s_penable;

    // Round-robin search: first requester after last_grant, wrapping around.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = NO_MSTS; k >= 1; k--) begin
            cand = GW'((int'(last_grant_reg) + k) % NO_MSTS);
            if (s_psel[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

`ifdef ADAM_APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] to_cnt_reg;

    // Watchdog: counts ACCESS cycles spent waiting on the slave.
    always_ff @(posedge seq_clk) begin
        if (seq_rst) begin
            to_cnt_reg <= '0;
        end else if (state_reg == SETUP) begin
            to_cnt_reg <= '0;
        end else if (state_reg == ACCESS && !m_pready) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    // A slave answering in the very last allowed cycle still gets a normal completion.
    assign timeout_hit = (state_reg == ACCESS) && !m_pready
                         && (to_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    assign xfer_done  = (state_reg == ACCESS) && (m_pready || timeout_hit);
    // A reset arriving mid-transfer abandons it silently: no response is returned.
    assign resp_valid = xfer_done && !seq_rst;

    // Next-state logic; pause wins over pending requests, but only from IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pause_req)      state_next = PAUSED;
                else if (arb_found) state_next = SETUP;
            end
            SETUP:  state_next = ACCESS;
            ACCESS: if (m_pready || timeout_hit) state_next = IDLE;
            PAUSED: if (!pause_req) state_next = IDLE;
            default: state_next = PAUSED;
        endcase
    end

    // State register; the granted request is captured when the bus is granted,
    // so requesters may drop psel afterwards without disturbing the transfer.
    always_ff @(posedge seq_clk) begin
        if (seq_rst) begin
            state_reg      <= PAUSED;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NO_MSTS - 1);
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            pstrb_reg      <= '0;
            pprot_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && state_next == SETUP) begin
                grant_reg  <= arb_idx;
                pwrite_reg <= s_pwrite[arb_idx];
                paddr_reg  <= s_paddr[arb_idx];
                pwdata_reg <= s_pwdata[arb_idx];
                pstrb_reg  <= s_pstrb[arb_idx];
                pprot_reg  <= s_pprot[arb_idx];
            end
            if (xfer_done) begin
                last_grant_reg <= grant_reg;
            end
        end
    end

    assign m_psel    = (state_reg == SETUP) || (state_reg == ACCESS);
    assign m_penable = (state_reg == ACCESS);
    assign m_pwrite  = pwrite_reg;
    assign m_paddr   = paddr_reg;
    assign m_pwdata  = pwdata_reg;
    assign m_pstrb   = pstrb_reg;
    assign m_pprot   = pprot_reg;
    assign pause_ack = (state_reg == PAUSED);

    // Response routing: only the granted requester sees the completion; a
    // watchdog completion reports an error with zero read data.
    genvar gi;
    generate
        for (gi = 0; gi < NO_MSTS; gi++) begin : g_rsp
            assign s_pready[gi]  = resp_valid && (grant_reg == GW'(gi));
            assign s_pslverr[gi] = s_pready[gi] && (timeout_hit || m_pslverr);
            assign s_prdata[gi]  = (s_pready[gi] && !timeout_hit) ? m_prdata : '0;
        end
    endgenerate

endmodule
